// File: rtl/aznable_pkg.sv
// aznable_pkg: constants and types shared by the Aznable system block and its loaders.
//
// Contents:
//   IDX_*            ioctl/dn index values identifying the target ROM
//   REGION_SIZE_*    byte capacity of each target ROM
//   loader_state_e   rom_loader state encoding
//   region_limit()   byte capacity for a given index (0 for unknown indices)
package aznable_pkg;

  // Target ROM indices. The system block decodes dn_index with the same constants.
  localparam logic [7:0] IDX_PGROM  = 8'd0;
  localparam logic [7:0] IDX_CHROM  = 8'd1;
  localparam logic [7:0] IDX_PALROM = 8'd2;
  localparam logic [7:0] IDX_SPRROM = 8'd3;

  // Region sizes in bytes.
  localparam int unsigned REGION_SIZE_PGROM  = 32768;
  localparam int unsigned REGION_SIZE_CHROM  = 2048;
  localparam int unsigned REGION_SIZE_PALROM = 32;
  localparam int unsigned REGION_SIZE_SPRROM = 4096;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StHold = 2'd2
  } loader_state_e;

  // Unknown indices have zero capacity, so every byte aimed at them is rejected.
  function automatic logic [31:0] region_limit(input logic [7:0] index);
    logic [31:0] limit;
    case (index)
      IDX_PGROM:  limit = REGION_SIZE_PGROM;
      IDX_CHROM:  limit = REGION_SIZE_CHROM;
      IDX_PALROM: limit = REGION_SIZE_PALROM;
      IDX_SPRROM: limit = REGION_SIZE_SPRROM;
      default:    limit = 32'd0;
    endcase
    return limit;
  endfunction

endpackage

// File: rtl/rom_region_check.sv
// rom_region_check: combinational bounds check of a download byte against its target ROM.
//
// Ports:
//   index     target ROM index (see aznable_pkg IDX_*)
//   addr      byte address within the downloaded file
//   in_range  1 when addr is below the capacity of the indexed ROM
module rom_region_check
  import aznable_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 25
) (
  input  logic [7:0]            index,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_range
);

  logic [31:0] limit;

  always_comb begin
    limit    = region_limit(index);
    // Widen both sides so the compare is correct for any ADDR_WIDTH up to 64.
    in_range = (64'(addr) < 64'(limit));
  end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: converts the MiSTer ioctl download stream into the Aznable upload bus.
//
// Each accepted byte (ioctl_wr while ioctl_download is high) is range-checked against the
// size of its target ROM. In-range bytes appear on dn_addr/dn_data/dn_index with a one-cycle
// dn_wr strobe one cycle later; out-of-range bytes are dropped and set the sticky load_error.
// While program ROM (index 0) is being replaced, cpu_reset holds the CPU in reset and keeps
// it there for HOLD_CYCLES cycles afterwards; the same stretch is applied after system reset.
//
// Optional build macro:
//   ROM_LOADER_CHECKSUM_EN  adds output checksum[7:0], the mod-256 sum of the dn_data of
//                          every dn_wr pulse of the current download.
//
// Ports:
//   clk_sys         system clock
//   reset           synchronous, active-high reset
//   ioctl_download  high for the whole duration of a download
//   ioctl_index     target ROM index
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte address within the file
//   ioctl_dout      byte data
//   dn_addr         upload address
//   dn_data         upload data
//   dn_index        upload target index (holds between writes)
//   dn_wr           one-cycle upload write strobe
//   cpu_reset       CPU reset request, OR'd into the system reset by the top level
//   load_done       one-cycle pulse at the end of any download
//   load_error      sticky flag, set by any out-of-range byte, cleared when a download starts
//   checksum        (ROM_LOADER_CHECKSUM_EN only) running byte sum of the current download
module rom_loader
  import aznable_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned DN_ADDR_WIDTH = 17
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ioctl_download,
  input  logic [7:0]               ioctl_index,
  input  logic                     ioctl_wr,
  input  logic [24:0]              ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  output logic [DN_ADDR_WIDTH-1:0] dn_addr,
  output logic [7:0]               dn_data,
  output logic [7:0]               dn_index,
  output logic                     dn_wr,
  output logic                     cpu_reset,
  output logic                     load_done,
  output logic                     load_error
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]               checksum
`endif
);

  localparam int unsigned CntWidth = $clog2(HOLD_CYCLES + 1);

  loader_state_e       state_q;
  logic [CntWidth-1:0] hold_cnt_q;
  logic                download_q;
  logic [7:0]          index_q;

  logic in_range;
  logic byte_valid;
  logic dl_rise;
  logic dl_fall;
  logic enter_load;

  rom_region_check #(
    .ADDR_WIDTH(25)
  ) u_region_check (
    .index   (ioctl_index),
    .addr    (ioctl_addr),
    .in_range(in_range)
  );

  // A byte coinciding with the falling edge of ioctl_download is dropped naturally here.
  assign byte_valid = ioctl_wr & ioctl_download;
  assign dl_rise    = ioctl_download & ~download_q;
  assign dl_fall    = ~ioctl_download & download_q;
  // A rising edge starts a new download from IDLE or HOLD; it takes priority over the hold
  // counter expiring in the same cycle.
  assign enter_load = dl_rise & (state_q != StLoad);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= StHold;
      hold_cnt_q <= CntWidth'(HOLD_CYCLES);
      // Cleared so a download still high at reset release is seen as a fresh rising edge.
      download_q <= 1'b0;
      index_q    <= IDX_PGROM;
      dn_addr    <= '0;
      dn_data    <= 8'd0;
      dn_index   <= 8'd0;
      dn_wr      <= 1'b0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      checksum   <= 8'd0;
`endif
    end else begin
      download_q <= ioctl_download;
      dn_wr      <= 1'b0;
      load_done  <= 1'b0;

      // Upload path: only bytes that pass the range check update the bus.
      if (byte_valid && in_range) begin
        dn_wr    <= 1'b1;
        dn_addr  <= ioctl_addr[DN_ADDR_WIDTH-1:0];
        dn_data  <= ioctl_dout;
        dn_index <= ioctl_index;
      end

      if (enter_load) begin
        state_q    <= StLoad;
        index_q    <= ioctl_index;
        load_error <= 1'b0;
        // Only program ROM replacement stalls the CPU; video/sprite ROMs load live.
        cpu_reset  <= (ioctl_index == IDX_PGROM);
      end else begin
        case (state_q)
          StLoad: begin
            if (dl_fall) begin
              load_done <= 1'b1;
              if (index_q == IDX_PGROM) begin
                state_q    <= StHold;
                hold_cnt_q <= CntWidth'(HOLD_CYCLES);
                cpu_reset  <= 1'b1;
              end else begin
                state_q <= StIdle;
              end
            end
          end
          StHold: begin
            // Leaving when the count would reach zero gives exactly HOLD_CYCLES cycles in HOLD.
            if (hold_cnt_q <= CntWidth'(1)) begin
              state_q    <= StIdle;
              hold_cnt_q <= '0;
              cpu_reset  <= 1'b0;
            end else begin
              hold_cnt_q <= hold_cnt_q - CntWidth'(1);
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end

      // After the download-start clear so an error in the very first cycle is not lost.
      if (byte_valid && !in_range) begin
        load_error <= 1'b1;
      end

`ifdef ROM_LOADER_CHECKSUM_EN
      // The last dn_wr of a download lands no later than the load_done cycle, so the sum is
      // final from then on until the next download starts.
      if (enter_load) begin
        checksum <= 8'd0;
      end else if (dn_wr) begin
        checksum <= checksum + dn_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

  localparam int unsigned HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic [7:0]  dn_index;
  logic        dn_wr;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  always #5 clk_sys = ~clk_sys;

  rom_loader #(
    .HOLD_CYCLES  (HOLD),
    .DN_ADDR_WIDTH(17)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_index      (dn_index),
    .dn_wr         (dn_wr),
    .cpu_reset     (cpu_reset),
    .load_done     (load_done),
    .load_error    (load_error)
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    .checksum      (checksum)
`endif
  );

  int n_checks = 0;
  int n_bad = 0;

  // Reference model state.
  logic [16:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  logic [7:0]  m_index = '0;
  logic        m_err = 1'b0;
  logic [7:0]  m_sum = '0;
  logic [7:0]  m_idx = '0;

  function automatic int unsigned limit_of(input logic [7:0] idx);
    case (idx)
      8'd0:    return 32768;
      8'd1:    return 2048;
      8'd2:    return 32;
      8'd3:    return 4096;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic model_reset;
    m_addr  = '0;
    m_data  = '0;
    m_index = '0;
    m_err   = 1'b0;
    m_sum   = '0;
  endtask

  // Counts consecutive samples (starting with the current one) where cpu_reset is high.
  task automatic wait_hold(input string tag);
    int hi;
    int noise;
    hi = 0;
    noise = 0;
    for (int i = 0; i < int'(HOLD) + 8; i++) begin
      if (cpu_reset !== 1'b1) break;
      hi++;
      if (dn_wr !== 1'b0) noise++;
      if (i > 0 && load_done !== 1'b0) noise++;
      tick();
    end
    check(tag, hi, HOLD);
    check({tag, "_quiet"}, noise, 0);
    check({tag, "_released"}, cpu_reset, 0);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
    m_idx = idx;
    m_err = 1'b0;
    m_sum = '0;
    check("start_cpu_reset", cpu_reset, idx == 8'd0);
    check("start_load_error", load_error, 0);
    check("start_dn_wr", dn_wr, 0);
  endtask

  task automatic send(input logic [24:0] addr, input logic [7:0] data);
    logic ok;
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    ok = (int'(addr) < int'(limit_of(m_idx)));
    if (ok) begin
      m_addr  = addr[16:0];
      m_data  = data;
      m_index = m_idx;
      m_sum   = m_sum + data;
    end else begin
      m_err = 1'b1;
    end
    check("dn_wr", dn_wr, ok);
    check("dn_addr", dn_addr, m_addr);
    check("dn_data", dn_data, m_data);
    check("dn_index", dn_index, m_index);
    check("load_error", load_error, m_err);
    check("load_cpu_reset", cpu_reset, m_idx == 8'd0);
    tick();
    check("dn_wr_one_cycle", dn_wr, 0);
  endtask

  task automatic end_dl;
    ioctl_download = 1'b0;
    tick();
    check("load_done", load_done, 1);
    check("done_load_error", load_error, m_err);
    check("done_dn_wr", dn_wr, 0);
`ifdef ROM_LOADER_CHECKSUM_EN
    check("checksum", checksum, m_sum);
`endif
    if (m_idx == 8'd0) begin
      wait_hold("hold_after_pgrom");
    end else begin
      check("done_cpu_reset", cpu_reset, 0);
      tick();
      check("load_done_one_cycle", load_done, 0);
      check("idle_cpu_reset", cpu_reset, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  idx;
    logic [24:0] addr;
    int unsigned lim;
    int          nb;
    int          lows;

    // Power-on reset and the stretched CPU reset that follows it.
    tick();
    tick();
    check("rst_dn_wr", dn_wr, 0);
    check("rst_dn_addr", dn_addr, 0);
    check("rst_dn_data", dn_data, 0);
    check("rst_dn_index", dn_index, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_error", load_error, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    reset = 1'b0;
    wait_hold("hold_after_reset");

    // Program ROM download with both boundary addresses and one just past the end.
    start_dl(8'd0);
    send(25'h0000, 8'hAA);
    send(25'h7FFF, 8'h55);
    send(25'h8000, 8'h99);
    end_dl();

    // Palette ROM: last valid byte then first invalid one.
    start_dl(8'd2);
    send(25'h1F, 8'h12);
    send(25'h20, 8'h34);
    end_dl();

    // Byte strobe coinciding with the falling edge of ioctl_download is dropped.
    start_dl(8'd1);
    send(25'd3, 8'h77);
    ioctl_addr = 25'd5;
    ioctl_dout = 8'hEE;
    ioctl_wr = 1'b1;
    ioctl_download = 1'b0;
    tick();
    ioctl_wr = 1'b0;
    check("fall_wr_dropped", dn_wr, 0);
    check("fall_load_done", load_done, 1);
    check("fall_dn_addr_held", dn_addr, m_addr);
    check("fall_cpu_reset", cpu_reset, 0);
    tick();
    check("fall_load_done_one_cycle", load_done, 0);

    // Strobe outside a download is ignored.
    ioctl_addr = 25'd2;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    check("no_download_wr", dn_wr, 0);
    tick();

    // Randomized downloads, including unknown index 4 (zero capacity).
    for (int d = 0; d < 6; d++) begin
      idx = 8'($urandom_range(0, 4));
      start_dl(idx);
      lim = limit_of(idx);
      nb = int'($urandom_range(3, 8));
      for (int b = 0; b < nb; b++) begin
        case ($urandom_range(0, 3))
          0:       addr = 25'(lim);
          1:       addr = (lim == 0) ? 25'd0 : 25'(lim - 1);
          default: addr = 25'($urandom_range(0, lim * 2 + 1));
        endcase
        send(addr, 8'($urandom_range(0, 255)));
      end
      end_dl();
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    start_dl(8'd3);
    send(25'd0, 8'hF0);
    send(25'd1, 8'h20);
    send(25'd2, 8'h01);
    end_dl();
    check("checksum_frozen", checksum, 8'h11);
`endif

    // Reset in the middle of a program download, with a byte strobe in the reset cycle.
    start_dl(8'd0);
    send(25'd10, 8'h01);
    send(25'd11, 8'h02);
    send(25'h1_0000, 8'h03);
    reset = 1'b1;
    ioctl_addr = 25'd12;
    ioctl_dout = 8'h04;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    model_reset();
    check("midrst_dn_wr", dn_wr, 0);
    check("midrst_load_error", load_error, 0);
    check("midrst_cpu_reset", cpu_reset, 1);
    check("midrst_dn_addr", dn_addr, 0);
    check("midrst_dn_data", dn_data, 0);
    reset = 1'b0;
    ioctl_download = 1'b0;
    tick();
    tick();
    // Raised during HOLD: must restart at LOAD and keep the CPU in reset past the hold window.
    start_dl(8'd0);
    send(25'h100, 8'h5A);
    lows = 0;
    for (int i = 0; i < int'(HOLD) + 4; i++) begin
      if (cpu_reset !== 1'b1) lows++;
      tick();
    end
    check("restart_cpu_reset_held", lows, 0);
    end_dl();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
